// File: rtl/sram_like_responder.sv
// SRAM-like request/response target: word-addressed memory behind a small in-order queue
// with a fixed response latency.
module sram_like_responder #(
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned QDEPTH     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int unsigned CntW = $clog2(QDEPTH + 1);
   localparam logic [PtrW-1:0] PtrLast  = PtrW'(QDEPTH - 1);
   localparam logic [CntW-1:0] CntFull  = CntW'(QDEPTH);
   localparam logic [2:0]      DownInit = 3'(LATENCY - 1);

   logic [31:0] mem [2**DEPTH_LOG2];

   logic [QDEPTH-1:0]     valid_q;
   logic [QDEPTH-1:0]     wr_q;
   logic [QDEPTH-1:0]     mis_q;
   logic [3:0]            wstrb_q [QDEPTH];
   logic [31:0]           wdata_q [QDEPTH];
   logic [DEPTH_LOG2-1:0] idx_q   [QDEPTH];
   logic [2:0]            down_q  [QDEPTH];
   logic [PtrW-1:0]       head_q;
   logic [PtrW-1:0]       tail_q;
   logic [CntW-1:0]       count_q;

   logic misaligned;
   logic accept;
   logic commit;
   logic unused_addr;

   // Upper address bits alias onto the same words.
   assign unused_addr = ^{addr[31:DEPTH_LOG2+2]};

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrLast) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      misaligned = 1'b0;
      case (size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = addr[0];
         default: misaligned = |addr[1:0];
      endcase
   end

   // No pop bypass: a full queue refuses new requests even while the head responds.
   assign addr_ok = ~reset & (count_q < CntFull);
   assign accept  = req & addr_ok;
   assign data_ok = ~reset & valid_q[head_q] & (down_q[head_q] == 3'd0);
   assign commit  = data_ok & wr_q[head_q] & ~mis_q[head_q];
   assign err     = data_ok & mis_q[head_q];
   assign rdata   = (data_ok & ~wr_q[head_q] & ~mis_q[head_q]) ? mem[idx_q[head_q]] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < QDEPTH; i++) begin
            if (valid_q[i] && down_q[i] != 3'd0) begin
               down_q[i] <= down_q[i] - 3'd1;
            end
         end
         if (data_ok) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= ptr_inc(head_q);
         end
         if (accept) begin
            valid_q[tail_q] <= 1'b1;
            wr_q[tail_q]    <= wr;
            mis_q[tail_q]   <= misaligned;
            wstrb_q[tail_q] <= wstrb;
            wdata_q[tail_q] <= wdata;
            idx_q[tail_q]   <= addr[DEPTH_LOG2+1:2];
            down_q[tail_q]  <= DownInit;
            tail_q          <= ptr_inc(tail_q);
         end
         case ({accept, data_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Memory has no reset; contents survive reset.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_q[head_q][b]) begin
               mem[idx_q[head_q]][8*b +: 8] <= wdata_q[head_q][8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: directed scenarios plus random traffic against a
// due-cycle queue model of the responder.
module tb_sram_like_responder;

   localparam int unsigned LAT = 2;
   localparam int unsigned QD  = 2;

   logic        clk = 1'b0;
   logic        reset, req, wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr, wdata;
   logic        addr_ok, data_ok, err;
   logic [31:0] rdata;

   always #5 clk = ~clk;

   sram_like_responder #(
      .DEPTH_LOG2 (12),
      .LATENCY    (LAT),
      .QDEPTH     (QD)
   ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .wr      (wr),
      .size    (size),
      .wstrb   (wstrb),
      .addr    (addr),
      .wdata   (wdata),
      .addr_ok (addr_ok),
      .data_ok (data_ok),
      .rdata   (rdata),
      .err     (err)
   );

   typedef struct {
      logic        wr;
      logic        mis;
      logic [3:0]  strb;
      logic [31:0] data;
      int          idx;
      int          due;
   } pend_t;

   pend_t       pend[$];
   logic [31:0] mdl_mem [4096];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          dok_seen = 0;
   int          acc_cyc = 0;
   int          dok_cyc = 0;
   logic        acc_seen = 1'b0;
   logic        last_aok = 1'b0;
   logic        last_err = 1'b0;
   logic [31:0] last_rdata = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
   task automatic tick(input logic rst, input logic rq, input logic w, input logic [1:0] sz,
                       input logic [3:0] st, input logic [31:0] a, input logic [31:0] d);
      logic        e_aok, e_dok, e_err, mis;
      logic [31:0] e_rd;
      pend_t       r;
      @(negedge clk);
      reset = rst; req = rq; wr = w; size = sz; wstrb = st; addr = a; wdata = d;
      #1;
      e_aok = !rst && (pend.size() < QD);
      e_dok = !rst && (pend.size() > 0) && (pend[0].due == cyc);
      e_err = e_dok && pend[0].mis;
      e_rd  = (e_dok && !pend[0].wr && !pend[0].mis) ? mdl_mem[pend[0].idx] : 32'h0;
      check("addr_ok", 32'(addr_ok), 32'(e_aok));
      check("data_ok", 32'(data_ok), 32'(e_dok));
      check("err", 32'(err), 32'(e_err));
      check("rdata", rdata, e_rd);
      last_aok = addr_ok;
      acc_seen = rq && addr_ok;
      if (acc_seen) acc_cyc = cyc;
      if (data_ok) begin
         dok_seen++;
         dok_cyc    = cyc;
         last_rdata = rdata;
         last_err   = err;
      end
      if (rst) begin
         pend.delete();
      end else begin
         if (e_dok) begin
            r = pend.pop_front();
            if (r.wr && !r.mis)
               for (int b = 0; b < 4; b++)
                  if (r.strb[b]) mdl_mem[r.idx][8*b +: 8] = r.data[8*b +: 8];
         end
         if (rq && e_aok) begin
            mis    = (sz == 2'd1) ? a[0] : (sz >= 2'd2) ? (a[1:0] != 2'b00) : 1'b0;
            r.wr   = w;
            r.mis  = mis;
            r.strb = st;
            r.data = d;
            r.idx  = int'((a >> 2) & 32'hFFF);
            r.due  = cyc + int'(LAT);
            pend.push_back(r);
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
   endtask

   // Hold one request until accepted, bounded.
   task automatic issue(input logic w, input logic [1:0] sz, input logic [3:0] st,
                        input logic [31:0] a, input logic [31:0] d);
      for (int t = 0; t < 10; t++) begin
         tick(1'b0, 1'b1, w, sz, st, a, d);
         if (acc_seen) break;
      end
      check("accepted", 32'(acc_seen), 32'd1);
   endtask

   initial begin
      int          k;
      int          rd_acc;
      logic [3:0]  pat;
      logic [31:0] a;

      repeat (3) tick(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);

      for (int i = 0; i < 16; i++) issue(1'b1, 2'd2, 4'hF, 32'(i * 4), $urandom());
      idle(4);

      // Write then read back.
      issue(1'b1, 2'd2, 4'hF, 32'h1c00_0010, 32'hDEAD_BEEF);
      issue(1'b0, 2'd2, 4'h0, 32'h1c00_0010, 32'h0);
      rd_acc = acc_cyc;
      idle(4);
      check("wr_rd_data", last_rdata, 32'hDEAD_BEEF);
      check("wr_rd_err", 32'(last_err), 32'd0);
      check("rd_latency", 32'(dok_cyc - rd_acc), 32'd2);

      // Partial-strobe write.
      issue(1'b1, 2'd2, 4'hF, 32'h0, 32'h1122_3344);
      issue(1'b1, 2'd2, 4'b0101, 32'h0, 32'hAABB_CCDD);
      issue(1'b0, 2'd2, 4'h0, 32'h0, 32'h0);
      idle(4);
      check("strobe_data", last_rdata, 32'h11BB_33DD);

      // Queue full with req held for three reads.
      dok_seen = 0;
      k        = 0;
      pat      = '0;
      for (int t = 0; t < 12; t++) begin
         tick(1'b0, k < 3, 1'b0, 2'd2, 4'h0, 32'h20 + 32'(k * 4), 32'h0);
         if (t < 4) pat = {pat[2:0], last_aok};
         if (acc_seen) k++;
      end
      check("qfull_aok_pattern", 32'(pat), 32'b1101);
      check("qfull_accepts", 32'(k), 32'd3);
      check("qfull_responses", 32'(dok_seen), 32'd3);

      // Four back-to-back reads to distinct words.
      dok_seen = 0;
      k        = 0;
      for (int t = 0; t < 14; t++) begin
         tick(1'b0, k < 4, 1'b0, 2'd2, 4'h0, 32'h2C + 32'(k * 4), 32'h0);
         if (acc_seen) k++;
      end
      check("b2b_responses", 32'(dok_seen), 32'd4);

      // Misaligned word write leaves memory untouched.
      issue(1'b1, 2'd2, 4'hF, 32'h4, 32'hCAFE_F00D);
      issue(1'b1, 2'd2, 4'hF, 32'h6, 32'hFFFF_FFFF);
      idle(4);
      check("mis_err", 32'(last_err), 32'd1);
      check("mis_rdata", last_rdata, 32'h0);
      issue(1'b0, 2'd2, 4'h0, 32'h4, 32'h0);
      idle(4);
      check("mis_nowrite", last_rdata, 32'hCAFE_F00D);

      // Reset while two writes are in flight.
      issue(1'b1, 2'd2, 4'hF, 32'h8, 32'h2222_2222);
      issue(1'b1, 2'd2, 4'hF, 32'hC, 32'h3333_3333);
      idle(4);
      dok_seen = 0;
      tick(1'b0, 1'b1, 1'b1, 2'd2, 4'hF, 32'h8, 32'h5555_5555);
      check("rst_wr0_acc", 32'(acc_seen), 32'd1);
      tick(1'b0, 1'b1, 1'b1, 2'd2, 4'hF, 32'hC, 32'h6666_6666);
      check("rst_wr1_acc", 32'(acc_seen), 32'd1);
      tick(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
      tick(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
      check("post_rst_aok", 32'(last_aok), 32'd1);
      idle(3);
      check("rst_no_dok", 32'(dok_seen), 32'd0);
      issue(1'b0, 2'd2, 4'h0, 32'h8, 32'h0);
      idle(4);
      check("rst_word2", last_rdata, 32'h2222_2222);
      issue(1'b0, 2'd2, 4'h0, 32'hC, 32'h0);
      idle(4);
      check("rst_word3", last_rdata, 32'h3333_3333);

      // Random traffic over 16 words with aliased upper bits and occasional reset.
      for (int t = 0; t < 500; t++) begin
         a = ($urandom() & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
         tick(($urandom() % 64) == 0, ($urandom() % 10) < 7, $urandom_range(0, 1) == 1,
              2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), a, $urandom());
      end
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
